barrier_approach: RTL

//  Parametrised successor to the fixed-lane barrier sprite. Animates one approaching obstacle from horizon to player line.

---
 rtl/barrier_approach.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/barrier_approach.sv
// rtl/barrier_approach.sv - one-lane approaching barrier sprite with perspective stages and hit window
// Optional feature macro: BARRIER_FLASH_EN (palette-1 flashes while in the hit window).
module barrier_approach #(
    parameter int CENTER_X   = 640,
    parameter int START_Y    = 360,
    parameter int END_Y      = 720,
    parameter int NUM_STAGES = 3,
    parameter int STAGE_STEP = 95,
    parameter int HIT_Y_LO   = 600,
    parameter int HIT_Y_HI   = 660
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_v_sync,
    input  logic        i_active,
    input  logic [3:0]  i_speed,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_sprite_hit,
    output logic        o_in_position,
    output logic        o_done,
    output logic [15:0] o_sprite_y
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_APPROACH = 2'd1,
        S_PARKED   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_sprite_y, w_sprite_y_nxt;
    logic [3:0]  r_speed, w_speed_nxt;
    logic        r_done, w_done_nxt;
    logic        r_vs_s1, r_vs_s2;
    logic        w_tick;
    logic [16:0] w_y_sum;

    assign w_tick  = r_vs_s1 & ~r_vs_s2;
    assign w_y_sum = {1'b0, r_sprite_y} + {13'd0, r_speed};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_sprite_y <= 16'(START_Y);
            r_speed    <= 4'd1;
            r_done     <= 1'b0;
            r_vs_s1    <= 1'b0;
            r_vs_s2    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sprite_y <= w_sprite_y_nxt;
            r_speed    <= w_speed_nxt;
            r_done     <= w_done_nxt;
            r_vs_s1    <= i_v_sync;
            r_vs_s2    <= r_vs_s1;
        end
    end

    // Dropping i_active wins over everything, including a tick in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_sprite_y_nxt = r_sprite_y;
        w_speed_nxt    = r_speed;
        w_done_nxt     = 1'b0;
        if (!i_active) begin
            w_state_nxt    = S_IDLE;
            w_sprite_y_nxt = 16'(START_Y);
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt    = S_APPROACH;
                    w_sprite_y_nxt = 16'(START_Y);
                    w_speed_nxt    = (i_speed == 4'd0) ? 4'd1 : i_speed;
                end
                S_APPROACH: begin
                    if (w_tick) begin
                        if (w_y_sum >= 17'(END_Y)) begin
                            w_sprite_y_nxt = 16'(END_Y);
                            w_done_nxt     = 1'b1;
                            w_state_nxt    = S_PARKED;
                        end else begin
                            w_sprite_y_nxt = w_y_sum[15:0];
                        end
                    end
                end
                S_PARKED: w_state_nxt = S_PARKED;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    logic [1:0]  w_stage;
    logic [16:0] w_width, w_x0, w_px, w_py, w_sy, w_dx, w_dy, w_dx_sh;
    logic [2:0]  w_shift;
    logic        w_hx, w_hy;
    logic [2:0]  w_row;
    logic [3:0]  w_col;
    logic [1:0]  w_idx;
    logic        w_flash;
    logic        w_unused;

    always_comb begin
        w_stage = 2'd0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if ({1'b0, r_sprite_y} >= 17'(START_Y + k * STAGE_STEP))
                w_stage = 2'(k);
        end
    end

    assign w_width  = 17'd64 << w_stage;
    assign w_x0     = 17'(CENTER_X) - (w_width >> 1);
    assign w_shift  = 3'd2 + {1'b0, w_stage};
    assign w_px     = {1'b0, i_x};
    assign w_py     = {1'b0, i_y};
    assign w_sy     = {1'b0, r_sprite_y};
    assign w_hx     = (w_px >= w_x0) && (w_px < w_x0 + w_width);
    assign w_hy     = (w_py >= w_sy) && (w_py < w_sy + 17'd32);
    assign w_dx     = w_px - w_x0;
    assign w_dy     = w_py - w_sy;
    assign w_dx_sh  = w_dx >> w_shift;
    assign w_col    = w_dx_sh[3:0];
    assign w_row    = w_dy[4:2];
    assign w_unused = ^{w_dx_sh[16:4], w_dy[16:5], w_dy[1:0]};

    // 16x8 bitmap: a solid red band across rows 3..6.
    function automatic logic [1:0] bitmap_idx(input logic [2:0] row, input logic [3:0] col);
        logic [31:0] line;
        line = (row >= 3'd3 && row <= 3'd6) ? {16{2'b01}} : 32'd0;
        return line[{col, 1'b0} +: 2];
    endfunction

    function automatic logic [23:0] palette(input logic [1:0] idx, input logic flash);
        case (idx)
            2'd1:    palette = flash ? 24'hFFFFFF : 24'hFF0000;
            2'd2:    palette = 24'h8ED8ED;
            2'd3:    palette = 24'hFFFFFF;
            default: palette = 24'h000000;
        endcase
    endfunction

    assign w_idx = bitmap_idx(w_row, w_col);

    assign o_in_position = (r_state == S_APPROACH) &&
                           ({1'b0, r_sprite_y} >= 17'(HIT_Y_LO)) &&
                           ({1'b0, r_sprite_y} <= 17'(HIT_Y_HI));

`ifdef BARRIER_FLASH_EN
    logic [1:0] r_frame_cnt;
    logic       r_flash_phase;

    // Phase flips once per four frame ticks.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_frame_cnt   <= 2'd0;
            r_flash_phase <= 1'b0;
        end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 2'd1;
            if (r_frame_cnt == 2'd3)
                r_flash_phase <= ~r_flash_phase;
        end
    end

    assign w_flash = r_flash_phase & o_in_position;
`else
    assign w_flash = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            {o_red, o_green, o_blue} <= 24'd0;
            o_sprite_hit             <= 1'b0;
        end else if (w_hx && w_hy && r_state == S_APPROACH) begin
            {o_red, o_green, o_blue} <= palette(w_idx, w_flash);
            o_sprite_hit             <= (w_idx != 2'd0);
        end else begin
            {o_red, o_green, o_blue} <= 24'd0;
            o_sprite_hit             <= 1'b0;
        end
    end

    assign o_done     = r_done;
    assign o_sprite_y = r_sprite_y;

endmodule
